// File: rtl/instr_fetch_queue_pkg.sv
// Shared frontend types for the instruction fetch queue: fetch slot entry and slot popcount.
package instr_fetch_queue_pkg;

   localparam int unsigned VLEN     = 32;
   // Upper bound on slots per fetch beat accepted by popcount_slots().
   localparam int unsigned MaxSlots = 8;

   typedef struct packed {
      logic [VLEN-1:0] addr;
      logic [31:0]     instr;
   } fetch_entry_t;

   function automatic int unsigned popcount_slots(input logic [MaxSlots-1:0] mask);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < MaxSlots; i++) begin
         cnt = cnt + {31'b0, mask[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction fetch queue.
interface instr_fetch_queue_if #(
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned DEPTH           = 8
);
   import instr_fetch_queue_pkg::*;

   logic [INSTR_PER_FETCH-1:0]      valid_i;
   logic [INSTR_PER_FETCH*VLEN-1:0] addr_i;
   logic [INSTR_PER_FETCH*32-1:0]   instr_i;
   logic                            fetch_ready_o;
   logic                            instr_valid_o;
   logic                            instr_ready_i;
   logic [31:0]                     instr_o;
   logic [VLEN-1:0]                 addr_o;
   logic                            is_compressed_o;
   logic [$clog2(DEPTH):0]          usage_o;

   modport master (
      output valid_i, addr_i, instr_i, instr_ready_i,
      input  fetch_ready_o, instr_valid_o, instr_o, addr_o, is_compressed_o, usage_o
   );

   modport slave (
      input  valid_i, addr_i, instr_i, instr_ready_i,
      output fetch_ready_o, instr_valid_o, instr_o, addr_o, is_compressed_o, usage_o
   );

endinterface

// File: rtl/instr_slot_compact.sv
// Valid-mask compaction: per-slot write offset (valid slots below it) and total valid count.
module instr_slot_compact import instr_fetch_queue_pkg::*; #(
   parameter int unsigned INSTR_PER_FETCH = 2,
   localparam int unsigned CntW = $clog2(INSTR_PER_FETCH + 1)
) (
   input  logic [INSTR_PER_FETCH-1:0]           valid_i,
   output logic [INSTR_PER_FETCH-1:0][CntW-1:0] offset_o,
   output logic [CntW-1:0]                      count_o
);

   logic [MaxSlots-1:0] valid_ext;

   always_comb begin
      valid_ext = '0;
      valid_ext[INSTR_PER_FETCH-1:0] = valid_i;
      count_o = CntW'(popcount_slots(valid_ext));
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         offset_o[i] = CntW'(popcount_slots(valid_ext & ((MaxSlots'(1) << i) - MaxSlots'(1))));
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: compacts re-aligned fetch slots into a circular FIFO, one issue per
// cycle. Define INSTR_FETCH_QUEUE_BYPASS_EN for same-cycle issue of the first slot when empty.
module instr_fetch_queue import instr_fetch_queue_pkg::*; #(
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned DEPTH           = 8
) (
   input logic                clk_i,
   input logic                rst_ni,
   input logic                flush_i,
   instr_fetch_queue_if.slave bus
);

   localparam int unsigned CntW   = $clog2(INSTR_PER_FETCH + 1);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned UsageW = PtrW + 1;

   fetch_entry_t                         mem_q [DEPTH];
   logic [PtrW-1:0]                      rptr_q, rptr_d, wptr_q, wptr_d;
   logic [UsageW-1:0]                    count_q, count_d;
   fetch_entry_t [INSTR_PER_FETCH-1:0]   slot_entry;
   logic [INSTR_PER_FETCH-1:0][CntW-1:0] slot_offset;
   logic [CntW-1:0]                      slot_cnt, push_cnt;
   logic [INSTR_PER_FETCH-1:0]           slot_we;
   logic [INSTR_PER_FETCH-1:0][PtrW-1:0] slot_idx;
   logic                                 fetch_ready, push, pop;
   logic                                 bypass_take;
   logic                                 head_valid;
   fetch_entry_t                         head;

   instr_slot_compact #(
      .INSTR_PER_FETCH(INSTR_PER_FETCH)
   ) u_compact (
      .valid_i (bus.valid_i),
      .offset_o(slot_offset),
      .count_o (slot_cnt)
   );

   always_comb begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         slot_entry[i].addr  = bus.addr_i[i*VLEN +: VLEN];
         slot_entry[i].instr = bus.instr_i[i*32 +: 32];
      end
   end

   // Free-space check uses the registered count only, so a taken push can never overflow.
   assign fetch_ready = (UsageW'(DEPTH) - count_q) >= UsageW'(INSTR_PER_FETCH);
   assign push        = (|bus.valid_i) && fetch_ready && !flush_i;
   assign pop         = (count_q != '0) && bus.instr_ready_i && !flush_i;
   assign push_cnt    = push ? slot_cnt : '0;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
   fetch_entry_t first_entry;
   logic         bypass_show;

   always_comb begin
      first_entry = slot_entry[0];
      for (int i = int'(INSTR_PER_FETCH) - 1; i >= 0; i--) begin
         if (bus.valid_i[i]) first_entry = slot_entry[i];
      end
   end

   assign bypass_show = (count_q == '0) && push;
   assign bypass_take = bypass_show && bus.instr_ready_i;

   always_comb begin
      head       = mem_q[rptr_q];
      head_valid = count_q != '0;
      if (bypass_show) begin
         head       = first_entry;
         head_valid = 1'b1;
      end
   end
`else
   assign bypass_take = 1'b0;

   always_comb begin
      head       = mem_q[rptr_q];
      head_valid = count_q != '0;
   end
`endif

   // A bypassed slot is always the lowest valid one (offset 0); the rest shift down by one.
   always_comb begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         slot_we[i]  = push && bus.valid_i[i] && !(bypass_take && (slot_offset[i] == '0));
         slot_idx[i] = wptr_q + PtrW'(slot_offset[i]) - PtrW'(bypass_take);
      end
   end

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         wptr_d  = wptr_q + PtrW'(push_cnt) - PtrW'(bypass_take);
         if (pop) rptr_d = rptr_q + PtrW'(1);
         count_d = count_q + UsageW'(push_cnt) - UsageW'(pop | bypass_take);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
         if (rst_ni && slot_we[i]) mem_q[slot_idx[i]] <= slot_entry[i];
      end
   end

   assign bus.fetch_ready_o   = fetch_ready;
   assign bus.usage_o         = count_q;
   assign bus.instr_valid_o   = head_valid;
   assign bus.instr_o         = head_valid ? head.instr : '0;
   assign bus.addr_o          = head_valid ? head.addr : '0;
   assign bus.is_compressed_o = head_valid && (head.instr[1:0] != 2'b11);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a queue-of-entries model fed by the driver, checked
// by a negedge monitor on every issue handshake.
module tb_instr_fetch_queue;
   import instr_fetch_queue_pkg::*;

   localparam int unsigned IPF   = 2;
   localparam int unsigned DEPTH = 8;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic flush_i = 1'b0;
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   fetch_entry_t exp_q[$];    // entries the DUT holds after the last edge
   fetch_entry_t pending[$];  // entries of the beat accepted this cycle

   instr_fetch_queue_if #(.INSTR_PER_FETCH(IPF), .DEPTH(DEPTH)) bus ();

   instr_fetch_queue #(
      .INSTR_PER_FETCH(IPF),
      .DEPTH          (DEPTH)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: expected head is the oldest held entry, or (bypass build) the first new slot.
   initial begin
      fetch_entry_t head;
      bit           exp_valid;
      bit           from_pending;
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            from_pending = (exp_q.size() == 0) && BypassEn && (pending.size() != 0);
            exp_valid    = (exp_q.size() != 0) || from_pending;
            chk("instr_valid", bus.instr_valid_o, exp_valid);
            if (bus.instr_valid_o && exp_valid) begin
               head = from_pending ? pending[0] : exp_q[0];
               chk("addr", bus.addr_o, head.addr);
               chk("instr", bus.instr_o, head.instr);
               chk("is_compressed", bus.is_compressed_o, head.instr[1:0] != 2'b11);
               if (bus.instr_ready_i) begin
                  if (from_pending) void'(pending.pop_front());
                  else void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic do_reset();
      mon_en            = 1'b0;
      rst_ni            = 1'b0;
      flush_i           = 1'b0;
      bus.valid_i       = '0;
      bus.instr_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      exp_q.delete();
      pending.delete();
      rst_ni = 1'b1;
      mon_en = 1'b1;
      chk("reset_usage", bus.usage_o, 0);
      chk("reset_fetch_ready", bus.fetch_ready_o, 1);
      chk("reset_instr_valid", bus.instr_valid_o, 0);
   endtask

   // One clock: drive a beat at posedge+1, update the model, check occupancy after the edge.
   task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] i0,
                        input logic [31:0] a1, input logic [31:0] i1,
                        input logic rdy, input logic fl);
      bit acc;
      bus.valid_i       = v;
      bus.addr_i        = {a1, a0};
      bus.instr_i       = {i1, i0};
      bus.instr_ready_i = rdy;
      flush_i           = fl;
      acc = (v != 2'b00) && !fl && ((DEPTH - exp_q.size()) >= IPF);
      if (acc) begin
         if (v[0]) pending.push_back('{addr: a0, instr: i0});
         if (v[1]) pending.push_back('{addr: a1, instr: i1});
      end
      @(posedge clk_i);
      #1;
      if (fl) begin
         exp_q.delete();
         pending.delete();
      end else begin
         while (pending.size() != 0) exp_q.push_back(pending.pop_front());
      end
      chk("usage", bus.usage_o, exp_q.size());
      chk("fetch_ready", bus.fetch_ready_o, (DEPTH - exp_q.size()) >= IPF);
   endtask

   task automatic idle(input logic rdy);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      return w;
   endfunction

   task automatic drain();
      for (int k = 0; k < 2 * DEPTH && exp_q.size() != 0; k++) idle(1'b1);
      chk("drain_usage", bus.usage_o, 0);
      chk("drain_model_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [31:0] pc;
      logic [1:0]  v;
      bus.addr_i  = '0;
      bus.instr_i = '0;
      do_reset();

      // Two slots, held, then issued in slot order.
      cycle(2'b11, 32'h1000, 32'h0000_0013, 32'h1004, 32'h0010_0093, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Gap compaction: only slot 1 valid, compressed instruction.
      cycle(2'b10, 32'h2000, 32'hdead_beef, 32'h2002, 32'h0000_4501, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Fill with no drain until the free-space check closes; further beats are ignored.
      pc = 32'h3000;
      for (int b = 0; b < 6; b++) begin
         cycle(2'b11, pc, rnd_instr(), pc + 4, rnd_instr(), 1'b0, 1'b0);
         pc = pc + 8;
      end
      drain();

      // Wrap-around with alternating ready.
      pc = 32'h4000;
      for (int b = 0; b < 20; b++) begin
         v = 2'($urandom_range(1, 3));
         cycle(v, pc, rnd_instr(), pc + 4, rnd_instr(), 1'(b % 2 == 0), 1'b0);
         pc = pc + 8;
      end
      drain();

      // Flush with five entries held and a push in the same cycle.
      cycle(2'b11, 32'h5000, rnd_instr(), 32'h5004, rnd_instr(), 1'b0, 1'b0);
      cycle(2'b11, 32'h5008, rnd_instr(), 32'h500c, rnd_instr(), 1'b0, 1'b0);
      cycle(2'b01, 32'h5010, rnd_instr(), 32'h5014, rnd_instr(), 1'b0, 1'b0);
      cycle(2'b11, 32'h5018, rnd_instr(), 32'h501c, rnd_instr(), 1'b0, 1'b1);
      idle(1'b0);

      // Empty queue, full beat, decoder ready (same-cycle issue in the bypass build).
      cycle(2'b11, 32'h6000, rnd_instr(), 32'h6004, rnd_instr(), 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Random traffic with occasional flushes and one mid-run reset.
      pc = 32'h8000;
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         v = 2'($urandom_range(0, 3));
         cycle(v, pc, rnd_instr(), pc + 4, rnd_instr(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 31) == 0));
         pc = pc + 8;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
